// File: rtl/pipe_control_unit.sv
// Pipelined LEGv8 control path: ID decode, ID/EX..MEM/WB control registers,
// flag register, load-use/branch/flag hazard stalls and EX-stage forwarding.
module pipe_control_unit #(
    parameter int REG_AW   = 5,
    parameter int ALUOP_W  = 3,
    parameter int LINK_REG = 30
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [31:0]        instruction,
    input  logic               id_rt_zero,
    input  logic               ex_zero,
    input  logic               ex_neg,
    input  logic               ex_ovf,
    input  logic               ex_carry,
    output logic               id_reg2Loc,
    output logic [1:0]         id_brTaken,
    output logic               id_unCondBr,
    output logic               pc_hold,
    output logic               ifid_flush,
    output logic [1:0]         ex_aluSrc,
    output logic [ALUOP_W-1:0] ex_aluOp,
    output logic               mem_memWrite,
    output logic               wb_regWrite,
    output logic [1:0]         wb_memToReg,
    output logic [REG_AW-1:0]  wb_rd,
    output logic [1:0]         fwdA,
    output logic [1:0]         fwdB,
    output logic [3:0]         flags_q
);

    localparam logic [REG_AW-1:0]  XZR     = '1;
    localparam logic [REG_AW-1:0]  LINK_RD = REG_AW'(LINK_REG);
    localparam logic [ALUOP_W-1:0] OP_ADD  = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] OP_SUB  = ALUOP_W'(3);
    localparam logic [4:0]         COND_LT = 5'h0B;

    localparam logic [1:0] SRC_REG   = 2'b00;
    localparam logic [1:0] SRC_DADDR = 2'b01;
    localparam logic [1:0] SRC_IMM12 = 2'b10;
    localparam logic [1:0] WB_ALU    = 2'b00;
    localparam logic [1:0] WB_MEM    = 2'b01;
    localparam logic [1:0] WB_PC4    = 2'b10;
    localparam logic [1:0] BR_NONE   = 2'b00;
    localparam logic [1:0] BR_OFFSET = 2'b01;
    localparam logic [1:0] BR_REG    = 2'b10;
    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    // src_a/src_b are the EX-stage operand registers for forwarding; unused
    // operands hold XZR so they can never match a forwarding destination.
    typedef struct packed {
        logic [1:0]         alu_src;
        logic [ALUOP_W-1:0] alu_op;
        logic               mem_write;
        logic               mem_read;
        logic               reg_write;
        logic [1:0]         mem_to_reg;
        logic [REG_AW-1:0]  rd;
        logic               flag_en;
        logic [REG_AW-1:0]  src_a;
        logic [REG_AW-1:0]  src_b;
    } idex_t;

    typedef struct packed {
        logic               mem_write;
        logic               mem_read;
        logic               reg_write;
        logic [1:0]         mem_to_reg;
        logic [REG_AW-1:0]  rd;
    } exmem_t;

    typedef struct packed {
        logic               reg_write;
        logic [1:0]         mem_to_reg;
        logic [REG_AW-1:0]  rd;
    } memwb_t;

    function automatic idex_t bubble_ctrl();
        idex_t b;
        b       = '0;
        b.src_a = XZR;
        b.src_b = XZR;
        return b;
    endfunction

    idex_t  idex_q,  idex_d;
    exmem_t exmem_q, exmem_d;
    memwb_t memwb_q, memwb_d;
    logic [3:0] flags_d;

    logic [REG_AW-1:0] f_rn, f_rm, f_rd;
    idex_t             dec;
    logic              dec_reg2loc;
    logic              dec_uncond;
    logic              is_b, is_blt, is_br, is_cbz;
    logic [REG_AW-1:0] hz_src_a, hz_src_b;
    logic [REG_AW-1:0] br_opnd;
    logic              load_use, br_stall, flag_stall, stall;
    logic              blt_taken;
    logic              unused_imm;

    assign f_rn       = instruction[9:5];
    assign f_rm       = instruction[20:16];
    assign f_rd       = instruction[4:0];
    assign unused_imm = ^instruction[15:10];

    // ------------------------------------------------------------------
    // ID decode
    // ------------------------------------------------------------------
    always_comb begin
        dec         = bubble_ctrl();
        dec_reg2loc = 1'b0;
        dec_uncond  = 1'b0;
        is_b        = 1'b0;
        is_blt      = 1'b0;
        is_br       = 1'b0;
        is_cbz      = 1'b0;
        hz_src_a    = XZR;
        hz_src_b    = XZR;
        casez (instruction[31:21])
            11'b1001000100?: begin
                dec.alu_src   = SRC_IMM12;
                dec.alu_op    = OP_ADD;
                dec.reg_write = 1'b1;
                dec.rd        = f_rd;
                dec.src_a     = f_rn;
                hz_src_a      = f_rn;
            end
            11'b10101011000, 11'b11101011000: begin
                dec_reg2loc   = 1'b1;
                dec.alu_src   = SRC_REG;
                dec.alu_op    = instruction[30] ? OP_SUB : OP_ADD;
                dec.reg_write = 1'b1;
                dec.rd        = f_rd;
                dec.flag_en   = 1'b1;
                dec.src_a     = f_rn;
                dec.src_b     = f_rm;
                hz_src_a      = f_rn;
                hz_src_b      = f_rm;
            end
            11'b000101?????: begin
                dec_uncond = 1'b1;
                is_b       = 1'b1;
            end
            11'b100101?????: begin
                dec_uncond     = 1'b1;
                is_b           = 1'b1;
                dec.reg_write  = 1'b1;
                dec.mem_to_reg = WB_PC4;
                dec.rd         = LINK_RD;
            end
            11'b01010100???: begin
                is_blt = (f_rd == COND_LT);
            end
            11'b11010110000: begin
                is_br    = 1'b1;
                hz_src_a = f_rn;
            end
            11'b10110100???: begin
                is_cbz   = 1'b1;
                hz_src_b = f_rd;
            end
            11'b11111000010: begin
                dec.alu_src    = SRC_DADDR;
                dec.alu_op     = OP_ADD;
                dec.mem_read   = 1'b1;
                dec.reg_write  = 1'b1;
                dec.mem_to_reg = WB_MEM;
                dec.rd         = f_rd;
                dec.src_a      = f_rn;
                hz_src_a       = f_rn;
            end
            11'b11111000000: begin
                dec.alu_src   = SRC_DADDR;
                dec.alu_op    = OP_ADD;
                dec.mem_write = 1'b1;
                dec.src_a     = f_rn;
                dec.src_b     = f_rd;
                hz_src_a      = f_rn;
                hz_src_b      = f_rd;
            end
            default: begin
                dec = bubble_ctrl();
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Hazards and branch resolution
    // ------------------------------------------------------------------
    always_comb begin
        br_opnd = is_cbz ? f_rd : f_rn;

        load_use = idex_q.mem_read && (idex_q.rd != XZR) &&
                   ((idex_q.rd == hz_src_a) || (idex_q.rd == hz_src_b));

        // Branch operands are compared in ID, so a result still in EX, or a
        // load still in MEM, cannot be forwarded in time.
        br_stall = (is_cbz || is_br) &&
                   ((idex_q.reg_write && (idex_q.rd != XZR) && (idex_q.rd == br_opnd)) ||
                    (exmem_q.mem_read && (exmem_q.rd != XZR) && (exmem_q.rd == br_opnd)));

        flag_stall = is_blt && idex_q.flag_en;
        stall      = load_use || br_stall || flag_stall;

        blt_taken = is_blt && (flags_q[3] ^ flags_q[1]);

        id_brTaken = BR_NONE;
        if (!stall) begin
            if (is_br) begin
                id_brTaken = BR_REG;
            end else if (is_b || blt_taken || (is_cbz && id_rt_zero)) begin
                id_brTaken = BR_OFFSET;
            end
        end

        pc_hold     = stall;
        ifid_flush  = !stall && (id_brTaken != BR_NONE);
        id_reg2Loc  = dec_reg2loc;
        id_unCondBr = dec_uncond;
    end

    // ------------------------------------------------------------------
    // Pipeline register next-state
    // ------------------------------------------------------------------
    always_comb begin
        idex_d = stall ? bubble_ctrl() : dec;

        exmem_d            = '0;
        exmem_d.mem_write  = idex_q.mem_write;
        exmem_d.mem_read   = idex_q.mem_read;
        exmem_d.reg_write  = idex_q.reg_write;
        exmem_d.mem_to_reg = idex_q.mem_to_reg;
        exmem_d.rd         = idex_q.rd;

        memwb_d            = '0;
        memwb_d.reg_write  = exmem_q.reg_write;
        memwb_d.mem_to_reg = exmem_q.mem_to_reg;
        memwb_d.rd         = exmem_q.rd;

        flags_d = idex_q.flag_en ? {ex_neg, ex_zero, ex_ovf, ex_carry} : flags_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idex_q  <= bubble_ctrl();
            exmem_q <= '0;
            memwb_q <= '0;
            flags_q <= 4'b0000;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
            flags_q <= flags_d;
        end
    end

    // ------------------------------------------------------------------
    // EX-stage forwarding, EX/MEM has priority over MEM/WB
    // ------------------------------------------------------------------
    always_comb begin
        fwdA = FWD_RF;
        if (exmem_q.reg_write && (exmem_q.rd != XZR) && (exmem_q.rd == idex_q.src_a)) begin
            fwdA = FWD_EXMEM;
        end else if (memwb_q.reg_write && (memwb_q.rd != XZR) && (memwb_q.rd == idex_q.src_a)) begin
            fwdA = FWD_MEMWB;
        end

        fwdB = FWD_RF;
        if (exmem_q.reg_write && (exmem_q.rd != XZR) && (exmem_q.rd == idex_q.src_b)) begin
            fwdB = FWD_EXMEM;
        end else if (memwb_q.reg_write && (memwb_q.rd != XZR) && (memwb_q.rd == idex_q.src_b)) begin
            fwdB = FWD_MEMWB;
        end
    end

    assign ex_aluSrc    = idex_q.alu_src;
    assign ex_aluOp     = idex_q.alu_op;
    assign mem_memWrite = exmem_q.mem_write;
    assign wb_regWrite  = memwb_q.reg_write;
    assign wb_memToReg  = memwb_q.mem_to_reg;
    assign wb_rd        = memwb_q.rd;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Directed bench for pipe_control_unit: hand-built instruction stream with
// hand-computed control, hazard and forwarding expectations.
module tb_pipe_control_unit;

    logic        clk;
    logic        reset_n;
    logic [31:0] instruction;
    logic        id_rt_zero;
    logic        ex_zero, ex_neg, ex_ovf, ex_carry;
    logic        id_reg2Loc;
    logic [1:0]  id_brTaken;
    logic        id_unCondBr;
    logic        pc_hold;
    logic        ifid_flush;
    logic [1:0]  ex_aluSrc;
    logic [2:0]  ex_aluOp;
    logic        mem_memWrite;
    logic        wb_regWrite;
    logic [1:0]  wb_memToReg;
    logic [4:0]  wb_rd;
    logic [1:0]  fwdA, fwdB;
    logic [3:0]  flags_q;

    int total = 0;
    int bad   = 0;

    pipe_control_unit #(.REG_AW(5), .ALUOP_W(3), .LINK_REG(30)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .instruction  (instruction),
        .id_rt_zero   (id_rt_zero),
        .ex_zero      (ex_zero),
        .ex_neg       (ex_neg),
        .ex_ovf       (ex_ovf),
        .ex_carry     (ex_carry),
        .id_reg2Loc   (id_reg2Loc),
        .id_brTaken   (id_brTaken),
        .id_unCondBr  (id_unCondBr),
        .pc_hold      (pc_hold),
        .ifid_flush   (ifid_flush),
        .ex_aluSrc    (ex_aluSrc),
        .ex_aluOp     (ex_aluOp),
        .mem_memWrite (mem_memWrite),
        .wb_regWrite  (wb_regWrite),
        .wb_memToReg  (wb_memToReg),
        .wb_rd        (wb_rd),
        .fwdA         (fwdA),
        .fwdB         (fwdB),
        .flags_q      (flags_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] i_addi(int rd, int rn, int imm);
        return {10'b1001000100, 12'(imm), 5'(rn), 5'(rd)};
    endfunction
    function automatic logic [31:0] i_adds(int rd, int rn, int rm);
        return {11'b10101011000, 5'(rm), 6'd0, 5'(rn), 5'(rd)};
    endfunction
    function automatic logic [31:0] i_subs(int rd, int rn, int rm);
        return {11'b11101011000, 5'(rm), 6'd0, 5'(rn), 5'(rd)};
    endfunction
    function automatic logic [31:0] i_bl();
        return {6'b100101, 26'd8};
    endfunction
    function automatic logic [31:0] i_bcond(int cond);
        return {8'b01010100, 19'd2, 5'(cond)};
    endfunction
    function automatic logic [31:0] i_br(int rn);
        return {11'b11010110000, 5'd31, 6'd0, 5'(rn), 5'd0};
    endfunction
    function automatic logic [31:0] i_cbz(int rt);
        return {8'b10110100, 19'd3, 5'(rt)};
    endfunction
    function automatic logic [31:0] i_ldur(int rt, int rn);
        return {11'b11111000010, 9'd0, 2'b00, 5'(rn), 5'(rt)};
    endfunction
    function automatic logic [31:0] i_stur(int rt, int rn);
        return {11'b11111000000, 9'd0, 2'b00, 5'(rn), 5'(rt)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins);
        instruction = ins;
        #1;
    endtask

    initial begin
        reset_n     = 1'b1;
        instruction = 32'd0;
        id_rt_zero  = 1'b0;
        ex_zero     = 1'b0;
        ex_neg      = 1'b0;
        ex_ovf      = 1'b0;
        ex_carry    = 1'b0;
        #1 reset_n  = 1'b0;
        #2;
        chk("reset_all_outputs",
            {id_reg2Loc, id_brTaken, id_unCondBr, pc_hold, ifid_flush, ex_aluSrc, ex_aluOp,
             mem_memWrite, wb_regWrite, wb_memToReg, wb_rd, fwdA, fwdB, flags_q}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // back-to-back forwarding
        tick(); drive(i_addi(1, 0, 5));
        chk("addi_brtaken", id_brTaken, 2'b00);
        chk("addi_reg2loc", id_reg2Loc, 1'b0);
        tick(); drive(i_adds(2, 1, 1));
        chk("addi_ex_alusrc", ex_aluSrc, 2'b10);
        chk("addi_ex_aluop", ex_aluOp, 3'b010);
        chk("adds_reg2loc", id_reg2Loc, 1'b1);
        chk("adds_no_hold", pc_hold, 1'b0);
        tick(); drive(32'd0);
        chk("b2b_fwdA", fwdA, 2'b01);
        chk("b2b_fwdB", fwdB, 2'b01);
        chk("adds_ex_alusrc", ex_aluSrc, 2'b00);
        tick(); drive(i_addi(5, 0, 7));
        chk("addi_wb_regwrite", wb_regWrite, 1'b1);
        chk("addi_wb_rd", wb_rd, 5'd1);
        chk("addi_wb_memtoreg", wb_memToReg, 2'b00);
        tick(); drive(32'd0);
        tick(); drive(i_adds(6, 5, 7));
        tick(); drive(i_ldur(3, 0));
        chk("gap_fwdA", fwdA, 2'b10);
        chk("gap_fwdB", fwdB, 2'b00);

        // load-use
        tick(); drive(i_adds(4, 3, 3));
        chk("lu_hold", pc_hold, 1'b1);
        chk("lu_no_flush", ifid_flush, 1'b0);
        chk("ldur_ex_alusrc", ex_aluSrc, 2'b01);
        tick(); drive(i_adds(4, 3, 3));
        chk("lu_hold_released", pc_hold, 1'b0);
        chk("lu_ex_bubble_op", ex_aluOp, 3'b000);
        chk("lu_ex_bubble_src", ex_aluSrc, 2'b00);
        tick(); drive(32'd0);
        chk("lu_fwdA", fwdA, 2'b10);
        chk("lu_fwdB", fwdB, 2'b10);
        chk("ldur_wb_rd", wb_rd, 5'd3);
        chk("ldur_wb_memtoreg", wb_memToReg, 2'b01);
        tick(); drive(32'd0);
        chk("lu_wb_bubble", wb_regWrite, 1'b0);
        tick(); drive(i_subs(7, 1, 2));
        chk("adds4_wb_regwrite", wb_regWrite, 1'b1);
        chk("adds4_wb_rd", wb_rd, 5'd4);

        // flag stall then B.LT taken
        tick(); ex_neg = 1'b1; ex_ovf = 1'b0; drive(i_bcond(11));
        chk("blt_flag_stall", pc_hold, 1'b1);
        chk("blt_stall_brtaken", id_brTaken, 2'b00);
        chk("blt_stall_flush", ifid_flush, 1'b0);
        tick(); ex_neg = 1'b0; drive(i_bcond(11));
        chk("subs_flags", flags_q, 4'b1000);
        chk("blt_brtaken", id_brTaken, 2'b01);
        chk("blt_flush", ifid_flush, 1'b1);
        chk("blt_uncond", id_unCondBr, 1'b0);
        chk("blt_no_hold", pc_hold, 1'b0);
        tick(); drive(i_bcond(0));
        chk("beq_unsupported", id_brTaken, 2'b00);
        chk("beq_no_flush", ifid_flush, 1'b0);

        // CBZ
        tick(); id_rt_zero = 1'b0; drive(i_cbz(9));
        chk("cbz_nz_brtaken", id_brTaken, 2'b00);
        chk("cbz_reg2loc", id_reg2Loc, 1'b0);
        tick(); id_rt_zero = 1'b1; drive(i_cbz(9));
        chk("cbz_z_brtaken", id_brTaken, 2'b01);
        chk("cbz_z_flush", ifid_flush, 1'b1);
        tick(); id_rt_zero = 1'b0; drive(32'd0);
        tick(); drive(i_addi(10, 0, 1));
        tick(); id_rt_zero = 1'b1; drive(i_cbz(10));
        chk("cbz_opnd_stall", pc_hold, 1'b1);
        chk("cbz_stall_brtaken", id_brTaken, 2'b00);
        chk("cbz_stall_flush", ifid_flush, 1'b0);
        tick(); drive(i_cbz(10));
        chk("cbz_after_stall_hold", pc_hold, 1'b0);
        chk("cbz_after_stall_brtaken", id_brTaken, 2'b01);

        // BL / BR
        tick(); id_rt_zero = 1'b0; drive(i_bl());
        chk("bl_brtaken", id_brTaken, 2'b01);
        chk("bl_uncond", id_unCondBr, 1'b1);
        chk("bl_flush", ifid_flush, 1'b1);
        tick(); drive(32'd0);
        tick(); drive(i_br(30));
        chk("br_brtaken", id_brTaken, 2'b10);
        chk("br_flush", ifid_flush, 1'b1);
        tick(); drive(32'd0);
        chk("bl_wb_regwrite", wb_regWrite, 1'b1);
        chk("bl_wb_rd", wb_rd, 5'd30);
        chk("bl_wb_memtoreg", wb_memToReg, 2'b10);

        // XZR never forwards; EX/MEM priority; STUR uses Rd as B
        tick(); drive(i_addi(31, 0, 1));
        tick(); drive(i_adds(1, 31, 31));
        tick(); drive(i_addi(12, 0, 1));
        chk("xzr_fwdA", fwdA, 2'b00);
        chk("xzr_fwdB", fwdB, 2'b00);
        tick(); drive(i_addi(12, 0, 2));
        tick(); drive(i_adds(13, 12, 12));
        tick(); ex_zero = 1'b1; ex_carry = 1'b1; drive(i_stur(13, 14));
        chk("prio_fwdA", fwdA, 2'b01);
        chk("prio_fwdB", fwdB, 2'b01);
        tick(); ex_zero = 1'b0; ex_carry = 1'b0; drive(32'd0);
        chk("adds_flags_zc", flags_q, 4'b0101);
        chk("stur_fwdA", fwdA, 2'b00);
        chk("stur_fwdB", fwdB, 2'b01);
        chk("stur_ex_alusrc", ex_aluSrc, 2'b01);
        tick(); drive(32'd0);
        chk("stur_mem_write", mem_memWrite, 1'b1);
        tick(); drive(i_ldur(3, 0));
        chk("bubble_mem_write", mem_memWrite, 1'b0);

        // reset during load-use stall
        tick(); drive(i_adds(4, 3, 3));
        chk("rst_pre_hold", pc_hold, 1'b1);
        reset_n = 1'b0;
        drive(32'd0);
        chk("rst_mid_all_outputs",
            {id_reg2Loc, id_brTaken, id_unCondBr, pc_hold, ifid_flush, ex_aluSrc, ex_aluOp,
             mem_memWrite, wb_regWrite, wb_memToReg, wb_rd, fwdA, fwdB, flags_q}, 32'd0);
        chk("rst_mid_flags", flags_q, 4'b0000);
        @(negedge clk);
        reset_n = 1'b1;
        tick(); drive(i_adds(4, 3, 3));
        chk("post_rst_hold", pc_hold, 1'b0);
        chk("post_rst_reg2loc", id_reg2Loc, 1'b1);
        chk("post_rst_ex_op", ex_aluOp, 3'b000);
        tick(); drive(32'd0);
        chk("post_rst_decode_ex_op", ex_aluOp, 3'b010);
        chk("post_rst_fwdA", fwdA, 2'b00);
        chk("post_rst_flags", flags_q, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
